// File: rtl/sw_cond_pkg.sv
// Shared constants, payload types and helpers for the slide-switch conditioner.
package sw_cond_pkg;

  localparam int unsigned GLITCH_W = 8;
  localparam int unsigned STAB_W   = 4;

  // Per-bit edge pulses produced by one debounce slice.
  typedef struct packed {
    logic rise;
    logic fall;
  } sw_edge_t;

  // Width of the debounce tick counter. It is never narrower than one bit.
  function automatic int unsigned tick_cnt_w(input int unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bundle between the board pins and the control-decode stage.
interface switch_conditioner_if #(
  parameter int unsigned WIDTH = 16
);

  logic [WIDTH-1:0]                  sw_raw;
  logic [WIDTH-1:0]                  sw_clean;
  logic [WIDTH-1:0]                  sw_rise;
  logic [WIDTH-1:0]                  sw_fall;
  logic                              sample_tick;
  logic [sw_cond_pkg::GLITCH_W-1:0]  glitch_cnt;

  // Switch source / consumer side.
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sample_tick,
    input  glitch_cnt
  );

  // Conditioner side.
  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sample_tick,
    output glitch_cnt
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, tick-sampled stability counter,
// clean level and registered rise/fall pulses.
// With SW_GLITCH_CNT_EN defined, the slice also reports a rejected bounce.
module sw_debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_raw,
  input  logic     i_tick,
  output logic     o_clean,
  output sw_edge_t o_edge
`ifdef SW_GLITCH_CNT_EN
  ,
  output logic     o_reject_c
`endif
);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);

  logic              r_meta;
  logic              r_sync;
  logic              r_clean;
  logic [STAB_W-1:0] r_stab;
  logic              r_rise;
  logic              r_fall;
  logic              w_differs;
  logic              w_accept;

  // Two-stage synchroniser; the raw pin feeds nothing else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Acceptance decode for the current sample tick.
  always_comb begin
    w_differs = r_sync ^ r_clean;
    w_accept  = i_tick && w_differs && (r_stab == STAB_LAST);
  end

  // Stability counter and clean level, advanced only on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab  <= '0;
      r_clean <= 1'b0;
    end else if (i_tick) begin
      if (!w_differs) begin
        r_stab <= '0;
      end else if (r_stab == STAB_LAST) begin
        r_clean <= r_sync;
        r_stab  <= '0;
      end else begin
        r_stab <= r_stab + STAB_W'(1);
      end
    end
  end

  // Edge pulses land in the same cycle the clean level first changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept &&  r_sync;
      r_fall <= w_accept && !r_sync;
    end
  end

  assign o_clean     = r_clean;
  assign o_edge.rise = r_rise;
  assign o_edge.fall = r_fall;

`ifdef SW_GLITCH_CNT_EN
  // A tick that finds the input back at the clean level after partial progress.
  assign o_reject_c = i_tick && !w_differs && (r_stab != '0);
`endif

endmodule

// File: rtl/switch_conditioner.sv
// Slide-switch front end: synchronises, debounces and edge-detects the
// board switches for the control-decode stage.
// Optional feature macro: SW_GLITCH_CNT_EN (saturating rejected-bounce counter);
// when undefined glitch_cnt is tied to zero.
module switch_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  switch_conditioner_if.slave sw_if
);

  localparam int unsigned        TICK_W    = tick_cnt_w(TICK_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_cnt_nxt;
  logic              r_sample_tick;
  logic [WIDTH-1:0]  w_clean;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  sw_edge_t          w_edge [WIDTH];

  // Next value of the free-running sample divider.
  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
    if (r_tick_cnt == TICK_LAST) begin
      w_tick_cnt_nxt = '0;
    end
  end

  // Divider and registered tick, high while the counter sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt    <= '0;
      r_sample_tick <= 1'b0;
    end else begin
      r_tick_cnt    <= w_tick_cnt_nxt;
      r_sample_tick <= (w_tick_cnt_nxt == TICK_LAST);
    end
  end

`ifdef SW_GLITCH_CNT_EN
  logic [WIDTH-1:0]    w_reject;
  logic [GLITCH_W-1:0] r_glitch_cnt;
`endif

  // One independent debounce slice per switch.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_raw      (sw_if.sw_raw[gi]),
      .i_tick     (r_sample_tick),
      .o_clean    (w_clean[gi]),
      .o_edge     (w_edge[gi])
`ifdef SW_GLITCH_CNT_EN
      ,
      .o_reject_c (w_reject[gi])
`endif
    );
    assign w_rise[gi] = w_edge[gi].rise;
    assign w_fall[gi] = w_edge[gi].fall;
  end

`ifdef SW_GLITCH_CNT_EN
  // Saturating count of ticks on which at least one bounce was rejected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if ((|w_reject) && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign sw_if.glitch_cnt = r_glitch_cnt;
`else
  assign sw_if.glitch_cnt = GLITCH_W'(0);
`endif

  assign sw_if.sw_clean    = w_clean;
  assign sw_if.sw_rise     = w_rise;
  assign sw_if.sw_fall     = w_fall;
  assign sw_if.sample_tick = r_sample_tick;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with TICK_DIV=4, STABLE_SAMPLES=3, WIDTH=16.
// Expected edge pulses are queued when a switch change is driven and
// compared when the conditioner emits them.
module tb_switch_conditioner;
  import sw_cond_pkg::*;

  localparam int unsigned W = 16;

`ifdef SW_GLITCH_CNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   timeouts = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  switch_conditioner_if #(.WIDTH(W)) sw_if ();

  switch_conditioner #(
    .WIDTH          (W),
    .TICK_DIV       (4),
    .STABLE_SAMPLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_if (sw_if.slave)
  );

  // Advance to the next negedge where sample_tick is high (bounded).
  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sw_if.sample_tick === 1'b1) got = 1'b1;
    end
    if (!got) timeouts++;
  endtask

  // Watch up to limit negedges for any edge pulse; report what was seen.
  task automatic wait_pulse(input int limit, output bit found,
                            output logic [W-1:0] rise, output logic [W-1:0] fall,
                            output logic [W-1:0] clean, output int cycles);
    found = 1'b0; rise = '0; fall = '0; clean = '0; cycles = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      cycles++;
      if ((sw_if.sw_rise | sw_if.sw_fall) !== '0) begin
        found = 1'b1;
        rise  = sw_if.sw_rise;
        fall  = sw_if.sw_fall;
        clean = sw_if.sw_clean;
      end
    end
  endtask

  task automatic sb_push(input logic [W-1:0] rise, input logic [W-1:0] fall);
    exp_t e;
    e.rise = rise;
    e.fall = fall;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (sb_q.size() != 0);
    e  = '0;
    if (ok) e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    int n_ticks, first, last;
    rst_n = 1'b0;
    sw_if.sw_raw = 16'hFFFF;
    repeat (5) @(negedge clk);
    checks++; if (sw_if.sw_clean !== 16'h0000) begin errors++; $display("FAIL reset_clean got %h expected 0000", sw_if.sw_clean); end
    checks++; if (sw_if.sw_rise !== 16'h0000) begin errors++; $display("FAIL reset_rise got %h expected 0000", sw_if.sw_rise); end
    checks++; if (sw_if.sw_fall !== 16'h0000) begin errors++; $display("FAIL reset_fall got %h expected 0000", sw_if.sw_fall); end
    checks++; if (sw_if.sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b expected 0", sw_if.sample_tick); end
    checks++; if (sw_if.glitch_cnt !== 8'h00) begin errors++; $display("FAIL reset_glitch got %h expected 00", sw_if.glitch_cnt); end
    sw_if.sw_raw = 16'h0000;
    rst_n = 1'b1;
    n_ticks = 0; first = -1; last = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (sw_if.sample_tick === 1'b1) begin
        n_ticks++;
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++; if (n_ticks != 4) begin errors++; $display("FAIL tick_count got %0d expected 4", n_ticks); end
    checks++; if (first != 3 || last != 15) begin errors++; $display("FAIL tick_phase got first %0d last %0d expected 3 15", first, last); end
  endtask

  task automatic test_clean_step();
    bit found, ok; logic [W-1:0] rise, fall, clean; int cyc; exp_t e;
    sw_if.sw_raw[2] = 1'b1;
    sb_push(16'h0004, 16'h0000);
    wait_pulse(20, found, rise, fall, clean, cyc);
    sb_pop(e, ok);
    checks++; if (!found || !ok) begin errors++; $display("FAIL step_seen got found=%b queued=%b expected 1 1", found, ok); end
    checks++; if (rise !== e.rise || fall !== e.fall) begin errors++; $display("FAIL step_edges got rise %h fall %h expected rise %h fall %h", rise, fall, e.rise, e.fall); end
    checks++; if (clean !== 16'h0004) begin errors++; $display("FAIL step_clean got %h expected 0004", clean); end
    checks++; if (cyc < 10 || cyc > 15) begin errors++; $display("FAIL step_latency got %0d cycles expected 10..15", cyc); end
    @(negedge clk);
    checks++; if (sw_if.sw_rise !== 16'h0000) begin errors++; $display("FAIL step_pulse_width got %h expected 0000", sw_if.sw_rise); end
    wait_pulse(16, found, rise, fall, clean, cyc);
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL step_extra_pulse got rise %h fall %h expected none", rise, fall); end
  endtask

  task automatic test_bounce();
    bit found1, found2; logic [W-1:0] rise, fall, clean; int cyc;
    wait_tick();
    sw_if.sw_raw[0] = 1'b1;
    wait_pulse(9, found1, rise, fall, clean, cyc);
    sw_if.sw_raw[0] = 1'b0;
    wait_pulse(16, found2, rise, fall, clean, cyc);
    checks++; if (found1 || found2) begin errors++; $display("FAIL bounce_pulse got pulse %b/%b expected none", found1, found2); end
    checks++; if (sw_if.sw_clean !== 16'h0004) begin errors++; $display("FAIL bounce_clean got %h expected 0004", sw_if.sw_clean); end
    checks++; if (sw_if.glitch_cnt !== (GLITCH_EN ? 8'h01 : 8'h00)) begin errors++; $display("FAIL bounce_glitch got %h expected %h", sw_if.glitch_cnt, GLITCH_EN ? 8'h01 : 8'h00); end
  endtask

  task automatic test_multi_bit();
    bit found, ok; logic [W-1:0] rise, fall, clean; int cyc; exp_t e;
    logic [W-1:0] pattern [3];
    logic [W-1:0] exp_clean [3];
    pattern[0] = 16'h0000; pattern[1] = 16'hFFC3; pattern[2] = 16'h0000;
    exp_clean[0] = 16'h0000; exp_clean[1] = 16'hFFC3; exp_clean[2] = 16'h0000;
    sb_push(16'h0000, 16'h0004);
    sb_push(16'hFFC3, 16'h0000);
    sb_push(16'h0000, 16'hFFC3);
    for (int k = 0; k < 3; k++) begin
      sw_if.sw_raw = pattern[k];
      wait_pulse(20, found, rise, fall, clean, cyc);
      sb_pop(e, ok);
      checks++; if (!found || !ok) begin errors++; $display("FAIL multi_seen[%0d] got found=%b queued=%b expected 1 1", k, found, ok); end
      checks++; if (rise !== e.rise || fall !== e.fall) begin errors++; $display("FAIL multi_edges[%0d] got rise %h fall %h expected rise %h fall %h", k, rise, fall, e.rise, e.fall); end
      checks++; if (clean !== exp_clean[k]) begin errors++; $display("FAIL multi_clean[%0d] got %h expected %h", k, clean, exp_clean[k]); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_count();
    bit found, ok; logic [W-1:0] rise, fall, clean; int cyc; exp_t e;
    wait_tick();
    sw_if.sw_raw[1] = 1'b1;
    wait_pulse(9, found, rise, fall, clean, cyc);
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL midrst_early got rise %h expected none", rise); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (sw_if.sw_clean !== 16'h0000 || sw_if.sw_rise !== 16'h0000) begin errors++; $display("FAIL midrst_in_reset got clean %h rise %h expected 0000 0000", sw_if.sw_clean, sw_if.sw_rise); end
    checks++; if (sw_if.glitch_cnt !== 8'h00) begin errors++; $display("FAIL midrst_glitch got %h expected 00", sw_if.glitch_cnt); end
    rst_n = 1'b1;
    sb_push(16'h0002, 16'h0000);
    wait_pulse(20, found, rise, fall, clean, cyc);
    sb_pop(e, ok);
    checks++; if (!found || !ok) begin errors++; $display("FAIL midrst_seen got found=%b queued=%b expected 1 1", found, ok); end
    checks++; if (rise !== e.rise || fall !== e.fall) begin errors++; $display("FAIL midrst_edges got rise %h fall %h expected rise %h fall %h", rise, fall, e.rise, e.fall); end
    checks++; if (cyc < 11 || cyc > 13) begin errors++; $display("FAIL midrst_latency got %0d cycles expected 11..13", cyc); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      wait_tick();
      sw_if.sw_raw[3] = 1'b1;
      repeat (5) @(negedge clk);
      sw_if.sw_raw[3] = 1'b0;
      if (n == 9) begin
        repeat (4) @(negedge clk);
        checks++; if (sw_if.glitch_cnt !== (GLITCH_EN ? 8'd10 : 8'd0)) begin errors++; $display("FAIL glitch_10 got %0d expected %0d", sw_if.glitch_cnt, GLITCH_EN ? 10 : 0); end
      end
    end
    repeat (4) @(negedge clk);
    checks++; if (sw_if.glitch_cnt !== (GLITCH_EN ? 8'hFF : 8'h00)) begin errors++; $display("FAIL glitch_sat got %h expected %h", sw_if.glitch_cnt, GLITCH_EN ? 8'hFF : 8'h00); end
    checks++; if (sw_if.sw_clean !== 16'h0002) begin errors++; $display("FAIL sat_clean got %h expected 0002", sw_if.sw_clean); end
  endtask

  task automatic test_bounds();
    checks++; if (timeouts != 0) begin errors++; $display("FAIL tick_timeout got %0d expected 0", timeouts); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d expected 0", sb_q.size()); end
  endtask

  initial begin
    sw_if.sw_raw = '0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_multi_bit();
    test_reset_mid_count();
    test_saturation();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
